regfile_rename: RTL and testbench

- Architectural register file with per-register rename tags, sitting between issue and the reorder buffer commit port.
- Issue reads source operands from it. If a source is still in flight, it returns the producing ROB tag instead of a value, and marks the destination register as renamed.
- The ROB commit port writes values back in program order.
- A misbranch flush discards all outstanding renames in one cycle.

---
 rtl/regfile_rename.sv | 91 +++++++++
 tb/tb_regfile_rename.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags.
// Issue reads operands (or producing ROB tags); the ROB commit port writes results back.
module regfile_rename #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int ROB_TAG_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic [ROB_TAG_W-1:0]  rs1_tag,
  output logic [DATA_W-1:0]     rs1_val,
  output logic                  rs2_busy,
  output logic [ROB_TAG_W-1:0]  rs2_tag,
  output logic [DATA_W-1:0]     rs2_val,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic                  iss_has_rd,
  input  logic [ROB_TAG_W-1:0]  iss_tag,
  input  logic                  cm_valid,
  input  logic [REG_ADDR_W-1:0] cm_rd,
  input  logic [DATA_W-1:0]     cm_data,
  input  logic [ROB_TAG_W-1:0]  cm_tag
);

  logic [DATA_W-1:0]    val_q  [NUM_REGS];
  logic                 busy_q [NUM_REGS];
  logic [ROB_TAG_W-1:0] tag_q  [NUM_REGS];

  logic cm_hit;
  assign cm_hit = cm_valid && (cm_rd != '0) && busy_q[cm_rd] && (tag_q[cm_rd] == cm_tag);

  // Entry 0 is only ever written by reset, so it stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i]  <= '0;
        busy_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else if (rdy) begin
      if (cm_valid && (cm_rd != '0)) begin
        val_q[cm_rd] <= cm_data;
        if (cm_hit) busy_q[cm_rd] <= 1'b0;
      end
      // Flush wins over a same-cycle issue; issue wins over a same-cycle commit clear.
      if (flush) begin
        for (int i = 1; i < NUM_REGS; i++) busy_q[i] <= 1'b0;
      end else if (iss_valid && iss_has_rd && (iss_rd != '0)) begin
        busy_q[iss_rd] <= 1'b1;
        tag_q[iss_rd]  <= iss_tag;
      end
    end
  end

  always_comb begin
    rs1_busy = 1'b0;
    rs1_tag  = '0;
    rs1_val  = '0;
    if (rs1_addr != '0) begin
      rs1_busy = busy_q[rs1_addr];
      rs1_tag  = tag_q[rs1_addr];
      rs1_val  = val_q[rs1_addr];
      if (cm_hit && (cm_rd == rs1_addr)) begin
        rs1_busy = 1'b0;
        rs1_val  = cm_data;
      end
    end
  end

  always_comb begin
    rs2_busy = 1'b0;
    rs2_tag  = '0;
    rs2_val  = '0;
    if (rs2_addr != '0) begin
      rs2_busy = busy_q[rs2_addr];
      rs2_tag  = tag_q[rs2_addr];
      rs2_val  = val_q[rs2_addr];
      if (cm_hit && (cm_rd == rs2_addr)) begin
        rs2_busy = 1'b0;
        rs2_val  = cm_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Directed bench for regfile_rename: rename, commit bypass, stale commit, flush, stall, reset.
module tb_regfile_rename;
  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_tag, rs2_tag;
  logic [31:0] rs1_val, rs2_val;
  logic        iss_valid, iss_has_rd;
  logic [4:0]  iss_rd;
  logic [3:0]  iss_tag;
  logic        cm_valid;
  logic [4:0]  cm_rd;
  logic [31:0] cm_data;
  logic [3:0]  cm_tag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_rename dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_val(rs1_val),
    .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_val(rs2_val),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_has_rd(iss_has_rd), .iss_tag(iss_tag),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_data(cm_data), .cm_tag(cm_tag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 0; iss_has_rd = 0; iss_rd = 0; iss_tag = 0;
    cm_valid = 0; cm_rd = 0; cm_data = 0; cm_tag = 0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] t);
    iss_valid = 1; iss_has_rd = 1; iss_rd = rd; iss_tag = t;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [31:0] d, input logic [3:0] t);
    cm_valid = 1; cm_rd = rd; cm_data = d; cm_tag = t;
  endtask

  initial begin
    idle();
    rst = 1; rdy = 1; rs1_addr = 0; rs2_addr = 0;
    tick(); tick();
    rst = 0;

    // reset state
    rs1_addr = 5; rs2_addr = 0; #1;
    chk("rst_rs1_busy", rs1_busy, 0);
    chk("rst_rs1_val",  rs1_val, 0);
    chk("rst_rs1_tag",  rs1_tag, 0);
    chk("rst_rs2_busy", rs2_busy, 0);
    chk("rst_rs2_val",  rs2_val, 0);

    // writes to x0 dropped
    commit(0, 32'hDEADBEEF, 0); rs1_addr = 0; #1;
    chk("x0_bypass_val", rs1_val, 0);
    tick(); idle(); #1;
    chk("x0_val", rs1_val, 0);
    chk("x0_busy", rs1_busy, 0);

    // commit to non-busy register: no bypass, value lands next cycle
    commit(5, 32'h77, 0); rs1_addr = 5; #1;
    chk("nobusy_nobypass", rs1_val, 0);
    tick(); idle(); #1;
    chk("nobusy_commit_val", rs1_val, 32'h77);

    // rename x3 then commit with bypass
    issue(3, 7); rs1_addr = 3; #1;
    chk("no_issue_bypass", rs1_busy, 0);
    tick(); idle(); #1;
    chk("x3_busy", rs1_busy, 1);
    chk("x3_tag", rs1_tag, 7);
    commit(3, 32'h1234, 7); #1;
    chk("x3_byp_busy", rs1_busy, 0);
    chk("x3_byp_val", rs1_val, 32'h1234);
    tick(); idle(); #1;
    chk("x3_post_busy", rs1_busy, 0);
    chk("x3_post_val", rs1_val, 32'h1234);

    // stale commit on x4 leaves younger rename
    issue(4, 2); tick();
    issue(4, 5); tick(); idle();
    commit(4, 32'hAA, 2); rs2_addr = 4; #1;
    chk("x4_stale_byp_busy", rs2_busy, 1);
    tick(); idle(); #1;
    chk("x4_busy", rs2_busy, 1);
    chk("x4_tag", rs2_tag, 5);

    // same-cycle commit match and new issue on x6
    issue(6, 1); tick(); idle();
    commit(6, 32'h66, 1); issue(6, 9); tick(); idle();
    rs1_addr = 6; #1;
    chk("x6_busy", rs1_busy, 1);
    chk("x6_tag", rs1_tag, 9);

    // flush with same-cycle commit and issue
    issue(1, 3); tick();
    issue(2, 4); tick(); idle();
    rs1_addr = 1; rs2_addr = 2; #1;
    chk("x1_pre_busy", rs1_busy, 1);
    chk("x2_pre_tag", rs2_tag, 4);
    flush = 1; commit(8, 32'h55, 0); issue(9, 6);
    tick(); idle(); #1;
    chk("fl_x1_busy", rs1_busy, 0);
    chk("fl_x1_val", rs1_val, 0);
    chk("fl_x2_busy", rs2_busy, 0);
    rs1_addr = 9; rs2_addr = 8; #1;
    chk("fl_x9_busy", rs1_busy, 0);
    chk("fl_x8_val", rs2_val, 32'h55);
    rs1_addr = 4; rs2_addr = 6; #1;
    chk("fl_x4_busy", rs1_busy, 0);
    chk("fl_x4_val", rs1_val, 32'hAA);
    chk("fl_x6_busy", rs2_busy, 0);
    chk("fl_x6_val", rs2_val, 32'h66);

    // rdy low holds state
    rdy = 0; issue(10, 8); commit(3, 32'h9999, 0);
    tick(); tick(); idle(); rdy = 1;
    rs1_addr = 10; rs2_addr = 3; #1;
    chk("stall_x10_busy", rs1_busy, 0);
    chk("stall_x3_val", rs2_val, 32'h1234);

    // reset mid-traffic
    issue(11, 2); tick(); idle();
    rs1_addr = 11; #1;
    chk("x11_busy", rs1_busy, 1);
    rst = 1; issue(12, 3); commit(3, 32'hBBBB, 0);
    tick(); rst = 0; idle();
    rs1_addr = 11; rs2_addr = 3; #1;
    chk("rst2_x11_busy", rs1_busy, 0);
    chk("rst2_x3_val", rs2_val, 0);
    rs1_addr = 12; rs2_addr = 5; #1;
    chk("rst2_x12_busy", rs1_busy, 0);
    chk("rst2_x5_val", rs2_val, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
